ll_multi_list_mgr: RTL
======================

Name: ll_multi_list_mgr

Overview:
- Parametrised successor to the single-list linked-list engine.
- Manages NUM_LISTS independent linked lists that share one node pool of DEPTH entries, with an internal free-pointer FIFO.
- Supports push-tail, pop-head, peek-at-position and flush over a valid/ready request and response interface.
- Sits between the top-level request/response agent and the node storage; node data and next-pointer arrays are internal flops.

Parameters:
- NUM_LISTS, 4, number of lists; power of two, at least 2.
- DEPTH, 16, shared node count; power of two, at least 2.
- DATA_WD, 32, node payload width.
- PTR_WD, $clog2(DEPTH), node pointer width; derived localparam.
- LID_WD, $clog2(NUM_LISTS), list id width; derived localparam.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-high reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  block idle and able to accept.
- req_type  in  3  t_req_types.
- req_lid  in  LID_WD  target list.
- req_pos  in  PTR_WD  peek position, 0 = head.
- req_data  in  DATA_WD  push payload.
- resp_vld  out  1  response valid.
- resp_taken  in  1  response consumed.
- resp_type  out  3  t_resp_types.
- resp_data  out  DATA_WD  pop/peek data.
- resp_data_vld  out  1  resp_data meaningful.
- list_empty  out  NUM_LISTS  per-list empty flag.
- list_size  out  NUM_LISTS*(PTR_WD+1)  per-list size, packed, list 0 in the LSBs.
- free_cnt  out  PTR_WD+1  free nodes remaining.

Behaviour:
- Reset values:
  - All lists empty; list_empty all ones; list_size 0.
  - free_cnt = DEPTH; free FIFO holds pointers 0..DEPTH-1 in order.
  - req_rdy=1, resp_vld=0, resp_data_vld=0, resp_data=0, resp_type=OK.
- FSM states: IDLE, WALK, FLUSH, RESP.
  - req_rdy = (state==IDLE).
  - Accept occurs on req_vld & req_rdy in cycle T. Only one request is in flight.
- PUSH (0):
  - free_cnt==0 -> FULL; no state change.
  - Otherwise pop a free pointer p; data[p]=req_data.
  - If the list is non-empty: nxt[tail]=p. If empty: head=p. Then tail=p, size+1.
  - Response OK at T+1.
- POP (1):
  - Empty list -> EMPTY.
  - Otherwise resp_data=data[head], resp_data_vld=1, head=nxt[head], old head returned to the free FIFO, size-1.
  - Response OK at T+1.
- PEEK (2):
  - req_pos >= size -> BAD_POS at T+1.
  - Otherwise go to WALK: cur=head, cnt=req_pos; one hop per cycle until cnt==0.
  - resp_data=data[cur], OK at T+1+req_pos. List is unchanged.
- FLUSH (3):
  - Size n=0 -> OK at T+1.
  - Otherwise go to FLUSH and return one node per cycle from head, for n cycles.
  - List becomes empty; OK at T+1+n.
- Codes 4..7 -> BAD_REQ at T+1 (code 4 is subject to the optional feature).
- RESP state: resp_vld, resp_type and resp_data are held stable until resp_taken. The cycle resp_taken is seen, resp_vld drops and the FSM returns to IDLE, so req_rdy=1 the following cycle.
- resp_data_vld=1 only for successful POP and PEEK.
- Free FIFO is circular with PTR_WD-bit read/write pointers and a count. It cannot overflow, because pushes and pops on it never occur in the same cycle.
- list_size, list_empty and free_cnt update in the cycle after the operation that changes them.
- Reset mid-WALK, mid-FLUSH or in RESP: every list is empty, the free pool is full, and any pending response is discarded.

Optional Feature:
- Macro LL_PUSH_HEAD_EN.
- When defined: req_type 4 = PUSH_HEAD.
  - Allocates p; nxt[p]=head; head=p.
  - If the list was empty: tail=p.
  - Same FULL rule and T+1 latency as PUSH.
- When undefined: code 4 returns BAD_REQ and has no side effects.

Decomposition:
- Package ll_multi_list_pkg:
  - t_req_types: PUSH=0, POP=1, PEEK=2, FLUSH=3, PUSH_HEAD=4.
  - t_resp_types: OK=0, EMPTY=1, FULL=2, BAD_POS=3, BAD_REQ=4.
- Sub-module ll_free_ptr_fifo:
  - DEPTH/PTR_WD parameters; alloc and release ports; free_cnt output.
  - Reset-initialised contents.

Test Plan:
1. Reset -> free_cnt=16, list_empty=4'b1111, req_rdy=1, resp_vld=0.
2. Push 0xA, 0xB, 0xC to lid 2, then pop lid 2 -> OK, resp_data=0xA, resp_data_vld=1, list_size[2]=2, free_cnt=14. Pop an empty lid 0 -> EMPTY.
3. Push 16 nodes spread across lists, then a 17th push -> FULL; free_cnt=0 and sizes unchanged.
4. Push 10..14 to lid 1, peek pos 3 -> OK, data 13, resp_vld at T+4. Peek pos 5 -> BAD_POS at T+1.
5. Flush a 3-node lid 3 -> OK at T+4, free_cnt+3. A following push reuses the freed pointers and succeeds.
6. Hold resp_taken low for 5 cycles -> response stable, req_rdy=0. Assert reset_n during a WALK -> all outputs at reset values. Code 4 -> BAD_REQ without the macro, prepends with the macro.

Source files
------------

// File: rtl/ll_multi_list_pkg.sv
// Shared request/response encodings for the multi-list linked-list manager.
package ll_multi_list_pkg;

    typedef enum logic [2:0] {
        PUSH      = 3'd0,
        POP       = 3'd1,
        PEEK      = 3'd2,
        FLUSH     = 3'd3,
        PUSH_HEAD = 3'd4
    } t_req_types;

    typedef enum logic [2:0] {
        OK      = 3'd0,
        EMPTY   = 3'd1,
        FULL    = 3'd2,
        BAD_POS = 3'd3,
        BAD_REQ = 3'd4
    } t_resp_types;

endpackage

// File: rtl/ll_free_ptr_fifo.sv
// Circular FIFO of free node pointers; resets holding 0..DEPTH-1 in order.
// Alloc and release are never requested in the same cycle by the manager.
module ll_free_ptr_fifo #(
    parameter int DEPTH  = 16,
    parameter int PTR_WD = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc,
    output logic [PTR_WD-1:0] alloc_ptr,
    input  logic              rel,
    input  logic [PTR_WD-1:0] rel_ptr,
    output logic [PTR_WD:0]   free_cnt
);

    localparam logic [PTR_WD-1:0] PTR_ONE = PTR_WD'(1);
    localparam logic [PTR_WD:0]   CNT_ONE = (PTR_WD+1)'(1);

    logic [PTR_WD-1:0] mem_q [DEPTH];
    logic [PTR_WD-1:0] mem_d [DEPTH];
    logic [PTR_WD-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_WD:0]   cnt_q, cnt_d;

    // NOTE: blocking assignments in always_comb; each signal gets a default
    // first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (alloc) begin
            rd_d  = rd_q + PTR_ONE;
            cnt_d = cnt_d - CNT_ONE;
        end
        if (rel) begin
            mem_d[wr_q] = rel_ptr;
            wr_d        = wr_q + PTR_ONE;
            cnt_d       = cnt_d + CNT_ONE;
        end
    end

    // NOTE: non-blocking assignments for all flops; this memory is reset
    // because its contents are the free list itself, not payload.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= PTR_WD'(i);
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= (PTR_WD+1)'(DEPTH);
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign alloc_ptr = mem_q[rd_q];
    assign free_cnt  = cnt_q;

endmodule

// File: rtl/ll_multi_list_mgr.sv
// NUM_LISTS linked lists over a shared DEPTH-node pool; push/pop/peek/flush.
// Optional LL_PUSH_HEAD_EN enables request code 4 (PUSH_HEAD).
module ll_multi_list_mgr
    import ll_multi_list_pkg::*;
#(
    parameter  int NUM_LISTS = 4,
    parameter  int DEPTH     = 16,
    parameter  int DATA_WD   = 32,
    localparam int PTR_WD    = $clog2(DEPTH),
    localparam int LID_WD    = $clog2(NUM_LISTS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_vld,
    output logic                          req_rdy,
    input  logic [2:0]                    req_type,
    input  logic [LID_WD-1:0]             req_lid,
    input  logic [PTR_WD-1:0]             req_pos,
    input  logic [DATA_WD-1:0]            req_data,
    output logic                          resp_vld,
    input  logic                          resp_taken,
    output logic [2:0]                    resp_type,
    output logic [DATA_WD-1:0]            resp_data,
    output logic                          resp_data_vld,
    output logic [NUM_LISTS-1:0]          list_empty,
    output logic [NUM_LISTS*(PTR_WD+1)-1:0] list_size,
    output logic [PTR_WD:0]               free_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WALK  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [PTR_WD-1:0] PTR_ONE = PTR_WD'(1);
    localparam logic [PTR_WD:0]   SZ_ONE  = (PTR_WD+1)'(1);

    logic [1:0]         state_q, state_d;
    logic [LID_WD-1:0]  lid_q, lid_d;
    logic [PTR_WD-1:0]  cur_q, cur_d, cnt_q, cnt_d;
    logic [PTR_WD-1:0]  head_q [NUM_LISTS];
    logic [PTR_WD-1:0]  head_d [NUM_LISTS];
    logic [PTR_WD-1:0]  tail_q [NUM_LISTS];
    logic [PTR_WD-1:0]  tail_d [NUM_LISTS];
    logic [PTR_WD:0]    size_q [NUM_LISTS];
    logic [PTR_WD:0]    size_d [NUM_LISTS];
    logic [DATA_WD-1:0] data_q [DEPTH];
    logic [DATA_WD-1:0] data_d [DEPTH];
    logic [PTR_WD-1:0]  nxt_q  [DEPTH];
    logic [PTR_WD-1:0]  nxt_d  [DEPTH];
    t_resp_types        resp_type_q, resp_type_d;
    logic [DATA_WD-1:0] resp_data_q, resp_data_d;
    logic               resp_data_vld_q, resp_data_vld_d;

    logic               alloc, rel;
    logic [PTR_WD-1:0]  alloc_ptr, rel_ptr, hd;
    logic [LID_WD-1:0]  sel_lid;
    logic [PTR_WD:0]    sz;

    ll_free_ptr_fifo #(.DEPTH(DEPTH), .PTR_WD(PTR_WD)) u_free (
        .clk       (clk),
        .reset_n   (reset_n),
        .alloc     (alloc),
        .alloc_ptr (alloc_ptr),
        .rel       (rel),
        .rel_ptr   (rel_ptr),
        .free_cnt  (free_cnt)
    );

    // The list being operated on: the incoming request in IDLE, else the latched one.
    assign sel_lid = (state_q == S_IDLE) ? req_lid : lid_q;
    assign hd      = head_q[sel_lid];
    assign sz      = size_q[sel_lid];

    always_comb begin
        state_d         = state_q;
        lid_d           = lid_q;
        cur_d           = cur_q;
        cnt_d           = cnt_q;
        head_d          = head_q;
        tail_d          = tail_q;
        size_d          = size_q;
        data_d          = data_q;
        nxt_d           = nxt_q;
        resp_type_d     = resp_type_q;
        resp_data_d     = resp_data_q;
        resp_data_vld_d = resp_data_vld_q;
        alloc           = 1'b0;
        rel             = 1'b0;
        rel_ptr         = hd;
        case (state_q)
            S_IDLE: if (req_vld) begin
                lid_d           = req_lid;
                state_d         = S_RESP;
                resp_type_d     = OK;
                resp_data_vld_d = 1'b0;
                case (req_type)
                    PUSH: if (free_cnt == '0) resp_type_d = FULL;
                    else begin
                        alloc = 1'b1;
                        data_d[alloc_ptr] = req_data;
                        if (sz != '0) nxt_d[tail_q[sel_lid]] = alloc_ptr;
                        else          head_d[sel_lid] = alloc_ptr;
                        tail_d[sel_lid] = alloc_ptr;
                        size_d[sel_lid] = sz + SZ_ONE;
                    end
                    POP: if (sz == '0) resp_type_d = EMPTY;
                    else begin
                        resp_data_d     = data_q[hd];
                        resp_data_vld_d = 1'b1;
                        head_d[sel_lid] = nxt_q[hd];
                        rel             = 1'b1;
                        size_d[sel_lid] = sz - SZ_ONE;
                    end
                    PEEK: if ({1'b0, req_pos} >= sz) resp_type_d = BAD_POS;
                    else if (req_pos == '0) begin
                        resp_data_d     = data_q[hd];
                        resp_data_vld_d = 1'b1;
                    end else begin
                        state_d = S_WALK;
                        cur_d   = hd;
                        cnt_d   = req_pos;
                    end
                    FLUSH: if (sz != '0) state_d = S_FLUSH;
`ifdef LL_PUSH_HEAD_EN
                    PUSH_HEAD: if (free_cnt == '0) resp_type_d = FULL;
                    else begin
                        alloc = 1'b1;
                        data_d[alloc_ptr] = req_data;
                        nxt_d[alloc_ptr]  = hd;
                        head_d[sel_lid]   = alloc_ptr;
                        if (sz == '0) tail_d[sel_lid] = alloc_ptr;
                        size_d[sel_lid] = sz + SZ_ONE;
                    end
`endif
                    default: resp_type_d = BAD_REQ;
                endcase
            end
            // Last hop reads the target node directly so the response lands at T+1+pos.
            S_WALK: if (cnt_q == PTR_ONE) begin
                resp_data_d     = data_q[nxt_q[cur_q]];
                resp_data_vld_d = 1'b1;
                state_d         = S_RESP;
            end else begin
                cur_d = nxt_q[cur_q];
                cnt_d = cnt_q - PTR_ONE;
            end
            S_FLUSH: begin
                rel             = 1'b1;
                head_d[sel_lid] = nxt_q[hd];
                size_d[sel_lid] = sz - SZ_ONE;
                if (sz == SZ_ONE) state_d = S_RESP;
            end
            S_RESP: if (resp_taken) begin
                state_d         = S_IDLE;
                resp_data_vld_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q         <= S_IDLE;
            lid_q           <= '0;
            cur_q           <= '0;
            cnt_q           <= '0;
            head_q          <= '{default: '0};
            tail_q          <= '{default: '0};
            size_q          <= '{default: '0};
            resp_type_q     <= OK;
            resp_data_q     <= '0;
            resp_data_vld_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            lid_q           <= lid_d;
            cur_q           <= cur_d;
            cnt_q           <= cnt_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            size_q          <= size_d;
            resp_type_q     <= resp_type_d;
            resp_data_q     <= resp_data_d;
            resp_data_vld_q <= resp_data_vld_d;
        end
    end

    // Payload and links are only read for nodes reachable from a valid head.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        nxt_q  <= nxt_d;
    end

    always_comb begin
        list_size  = '0;
        list_empty = '0;
        for (int i = 0; i < NUM_LISTS; i++) begin
            list_size[i*(PTR_WD+1) +: (PTR_WD+1)] = size_q[i];
            list_empty[i] = (size_q[i] == '0);
        end
    end

    assign req_rdy       = (state_q == S_IDLE);
    assign resp_vld      = (state_q == S_RESP);
    assign resp_type     = resp_type_q;
    assign resp_data     = resp_data_q;
    assign resp_data_vld = resp_data_vld_q;

endmodule
